// File: rtl/word_assembler_hc_if.sv
// Byte-stream handshake and word-output bundle for word_assembler_hc.
// The master side is the byte source; the slave side is the assembler.
interface word_assembler_hc_if #(
    parameter int DATA_SIZE = 16,
    parameter int BYTE_SIZE = 8
);
    logic [BYTE_SIZE-1:0] byte_in;
    logic                 byte_valid;
    logic                 byte_ready;
    logic                 clear;
    logic [DATA_SIZE-1:0] word_out;
    logic                 load;
    logic                 busy;
    logic                 timeout_err;

    modport master (
        output byte_in, byte_valid, clear,
        input  byte_ready, word_out, load, busy, timeout_err
    );

    modport slave (
        input  byte_in, byte_valid, clear,
        output byte_ready, word_out, load, busy, timeout_err
    );
endinterface

// File: rtl/word_assembler_hc.sv
// Packs DATA_SIZE/BYTE_SIZE byte beats little-endian into one word and strobes load.
// A partial word idle for TIMEOUT_CYCLES is dropped and flagged in timeout_err.
//
// state   | meaning
// IDLE    | no partial word held, waiting for beat 0
// COLLECT | partial word held, idle counter running
// EMIT    | one cycle: word_out valid, load high, byte_ready low
module word_assembler_hc #(
    parameter int DATA_SIZE      = 16,
    parameter int BYTE_SIZE      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clock,
    input  logic               reset_n,
    word_assembler_hc_if.slave wif
);

    localparam int NBEATS = DATA_SIZE / BYTE_SIZE;
    localparam int CNT_W  = $clog2(NBEATS + 1);
    localparam int IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(NBEATS - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT =
        IDLE_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     beat_cnt_q;
    logic [DATA_SIZE-1:0] shift_q;
    logic [DATA_SIZE-1:0] shift_d;
    logic [IDLE_W-1:0]    idle_cnt_q;
    logic [DATA_SIZE-1:0] word_out_q;
    logic                 load_q;
    logic                 timeout_err_q;

    logic                 accept;
    logic                 last_beat;
    logic                 idle_expired;

    assign wif.byte_ready  = (state_q != EMIT) && !wif.clear;
    assign wif.word_out    = word_out_q;
    assign wif.load        = load_q;
    assign wif.busy        = (state_q == COLLECT);
    assign wif.timeout_err = timeout_err_q;

    assign accept    = wif.byte_valid && wif.byte_ready;
    assign last_beat = (beat_cnt_q == LAST_BEAT);
    // idle_cnt_q counts completed idle cycles, so the limit is hit on the edge
    // that would make it TIMEOUT_CYCLES.
    assign idle_expired = (TIMEOUT_CYCLES > 0) && (idle_cnt_q == IDLE_LIMIT);

    always_comb begin
        shift_d = shift_q;
        for (int k = 0; k < NBEATS; k++) begin
            if (beat_cnt_q == CNT_W'(k)) begin
                shift_d[k*BYTE_SIZE +: BYTE_SIZE] = wif.byte_in;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            beat_cnt_q    <= '0;
            shift_q       <= '0;
            idle_cnt_q    <= '0;
            word_out_q    <= '0;
            load_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            load_q <= 1'b0;
            case (state_q)
                EMIT: begin
                    state_q <= IDLE;
                    if (wif.clear) begin
                        timeout_err_q <= 1'b0;
                    end
                end
                default: begin
                    if (wif.clear) begin
                        state_q       <= IDLE;
                        beat_cnt_q    <= '0;
                        shift_q       <= '0;
                        idle_cnt_q    <= '0;
                        timeout_err_q <= 1'b0;
                    end else if (accept) begin
                        idle_cnt_q <= '0;
                        if (last_beat) begin
                            word_out_q <= shift_d;
                            load_q     <= 1'b1;
                            shift_q    <= '0;
                            beat_cnt_q <= '0;
                            state_q    <= EMIT;
                        end else begin
                            shift_q    <= shift_d;
                            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                            state_q    <= COLLECT;
                        end
                    end else if ((state_q == COLLECT) && (TIMEOUT_CYCLES > 0)) begin
                        if (idle_expired) begin
                            shift_q       <= '0;
                            beat_cnt_q    <= '0;
                            idle_cnt_q    <= '0;
                            timeout_err_q <= 1'b1;
                            state_q       <= IDLE;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/word_assembler_hc.md
Name: word_assembler_hc

Overview:
- Upstream feeder for the data register (DATA_SIZE-wide, `in` and `load` ports).
- Accepts a narrow byte stream over a valid/ready handshake and packs DATA_SIZE/BYTE_SIZE beats into one word, little-endian (first beat goes to the LSBs).
- On completion it presents the word on word_out and pulses load for one cycle, so the register captures it.
- A partial word that stalls longer than TIMEOUT_CYCLES is discarded and flagged.

Parameters:
- DATA_SIZE, 16, assembled word width. Must be an integer multiple of BYTE_SIZE.
- BYTE_SIZE, 8, width of one input beat.
- TIMEOUT_CYCLES, 255, idle cycles allowed mid-word before discard. 0 disables the timeout.

Ports:
- clock  input  1  main clock, all state updates on posedge.
- reset_n  input  1  reset, asynchronous, active-low.
- byte_in  input  BYTE_SIZE  input beat data.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  block can accept a beat this cycle.
- clear  input  1  synchronous abort: discard partial word and clear timeout_err.
- word_out  output  DATA_SIZE  last completed word. Connects to the register's `in`.
- load  output  1  one-cycle strobe, word_out newly valid. Connects to the register's `load`.
- busy  output  1  a partial word is held (state COLLECT).
- timeout_err  output  1  sticky, set when a partial word was discarded by timeout.

Behaviour:
- Clock and reset: one clock (clock). Reset is asynchronous and active-low (reset_n).
- Reset values (reset_n=0, immediate, independent of clock):
  - state=IDLE, beat count=0, shift buffer=0, idle counter=0.
  - word_out=0, load=0, busy=0, timeout_err=0.
- NBEATS = DATA_SIZE/BYTE_SIZE. The beat counter is ceil(log2(NBEATS+1)) bits wide.
- Handshake:
  - byte_ready = (state != EMIT) && !clear. This is combinational on state and clear only, never on byte_valid.
  - A beat is accepted on a posedge where byte_valid && byte_ready.
  - Beat k (0-based) is written to buffer bits [k*BYTE_SIZE +: BYTE_SIZE].
  - byte_valid with byte_ready=0 is ignored. The source must hold its data.
- States:
  - IDLE: waiting for the first beat. An accepted beat stores beat 0 and moves to COLLECT. If NBEATS==1, it moves directly to EMIT instead.
  - COLLECT: accepts further beats. Acceptance of beat NBEATS-1 moves to EMIT.
  - EMIT: lasts exactly one cycle.
    - On entry, word_out is registered from the full buffer (including the final beat) and load=1.
    - byte_ready=0 during EMIT.
    - Next state is IDLE. load returns to 0.
- Latency and throughput:
  - Final beat accepted at edge N → word_out updated and load=1 during cycle N..N+1 → register captures at edge N+1.
  - Sustained throughput is one word per NBEATS+1 cycles.
- word_out holds its value between completions. A timeout or clear never changes word_out.
- Timeout (TIMEOUT_CYCLES>0, COLLECT only):
  - The idle counter increments each cycle with no accepted beat and resets to 0 on any accepted beat.
  - When the counter reaches TIMEOUT_CYCLES: buffer and beat count are cleared, timeout_err=1, state=IDLE, and no load is issued.
  - A beat accepted in the same cycle as the counter reaches its limit wins: no timeout that cycle.
- clear:
  - When sampled high at a posedge in IDLE or COLLECT: state=IDLE, buffer, beat count and idle counter are cleared, and timeout_err=0.
  - Because byte_ready=0 while clear is high, no beat is accepted in that cycle.
  - clear in EMIT: the load pulse and word_out still complete, timeout_err is cleared, and the next state is IDLE.
  - timeout_err is otherwise cleared only by reset.
- Simultaneous timeout and clear: clear wins, so timeout_err ends at 0.
- busy = (state == COLLECT).
- Reset asserted mid-word: all state is lost, word_out=0, and no load is issued. After reset_n deasserts, the next beat is treated as beat 0.

Test Plan:
- Reset, then beats 0x34 then 0x12 on consecutive cycles (valid held high) → one cycle after the 2nd acceptance: word_out=0x1234, load=1 for exactly 1 cycle; the register then reads 0x1234.
- Back-to-back stream 0xAA,0xBB,0xCC,0xDD with valid held high → byte_ready drops to 0 for the one EMIT cycle. Sequence is load with word_out=0xBBAA, then load with word_out=0xDDCC. No beat is lost or duplicated.
- TIMEOUT_CYCLES=4: beat 0x55, then valid=0 for 4 cycles → timeout_err=1, busy=0, no load, word_out unchanged. Next beats 0x01,0x02 → word_out=0x0201.
- Beat 0x77, then clear=1 with byte_valid=1 and byte_in=0x88 in the same cycle → 0x88 not accepted and timeout_err=0. Next beats 0x11,0x22 → word_out=0x2211.
- Beat 0x99 accepted, then reset_n pulsed low between clock edges → outputs go to 0 immediately. After release, beats 0x0F,0xF0 → word_out=0xF00F.
- DATA_SIZE=8, BYTE_SIZE=8: single beat 0x3C → load one cycle later with word_out=0x3C. busy never asserts.
